// File: rtl/fusion_pkg.sv
// ============================================================================
// fusion_pkg
// Shared types and lane-count decode for the fusion accumulator.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fusion_pkg;

    typedef enum logic [1:0] {
        PREC_2 = 2'b00,
        PREC_4 = 2'b01,
        PREC_8 = 2'b10
    } prec_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } acc_state_e;

    localparam logic [1:0] c_prec_illegal = 2'b11;

    // Returns 0 for an illegal code so callers can use it as the legality test.
    function automatic logic [2:0] lanes_f(input logic [1:0] cfga, input logic [1:0] cfgb);
        if (cfga == c_prec_illegal || cfgb == c_prec_illegal)
            return 3'd0;
        if (cfga == PREC_8 && cfgb == PREC_8)
            return 3'd1;
        if ((cfga == PREC_8 && cfgb == PREC_4) || (cfga == PREC_4 && cfgb == PREC_8))
            return 3'd2;
        return 3'd4;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fusion_acc_lane.sv
// ============================================================================
// fusion_acc_lane
// One ACC_W-bit saturating accumulator with synchronous clear and sticky sat.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fusion_acc_lane #(
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             sgn,
    input  logic [ACC_W-1:0] addend,
    output logic [ACC_W-1:0] acc,
    output logic             sat
);

    localparam logic [ACC_W-1:0] c_smax = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] c_smin = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] c_umax = {ACC_W{1'b1}};

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             sat_q, sat_d;
    logic [ACC_W:0]   w_sum;
    logic             w_clip;
    logic [ACC_W-1:0] w_limit;

    always_comb begin
        if (sgn) begin
            w_sum   = {acc_q[ACC_W-1], acc_q} + {addend[ACC_W-1], addend};
            // Signed overflow shows as disagreement between the guard and MSB.
            w_clip  = w_sum[ACC_W] ^ w_sum[ACC_W-1];
            w_limit = w_sum[ACC_W] ? c_smin : c_smax;
        end else begin
            w_sum   = {1'b0, acc_q} + {1'b0, addend};
            w_clip  = w_sum[ACC_W];
            w_limit = c_umax;
        end
    end

    always_comb begin
        acc_d = acc_q;
        sat_d = sat_q;
        if (clr) begin
            acc_d = '0;
            sat_d = 1'b0;
        end else if (en) begin
            acc_d = w_clip ? w_limit : w_sum[ACC_W-1:0];
            sat_d = sat_q | w_clip;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            sat_q <= sat_d;
        end
    end

    assign acc = acc_q;
    assign sat = sat_q;

endmodule

`default_nettype wire

// File: rtl/fusion_accumulator.sv
// ============================================================================
// fusion_accumulator
// Accumulates 1/2/4 lanes of packed fusion-unit products over COUNT beats.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fusion_accumulator
    import fusion_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         cfga,
    input  logic [1:0]         cfgb,
    input  logic               sgn,
    input  logic [CNT_W-1:0]   count,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [63:0]        in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4*ACC_W-1:0] out_data,
    output logic [2:0]         out_lanes,
    output logic               sat,
    output logic               busy,
    output logic               err_cfg
);

    acc_state_e       state_q, state_d;
    logic [2:0]       lanes_q, lanes_d;
    logic             sgn_q, sgn_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             err_cfg_q, err_cfg_d;

    logic [2:0]       w_start_lanes;
    logic             w_start_ok;
    logic             w_beat;
    logic [3:0]       w_lane_en;
    logic [3:0]       w_lane_sat;
    logic [ACC_W-1:0] w_addend   [4];
    logic [ACC_W-1:0] w_lane_acc [4];

    // Extends (or truncates) the low fw bits of v to ACC_W bits.
    function automatic logic [ACC_W-1:0] ext_f(input logic [63:0] v, input int fw, input logic s);
        logic [ACC_W-1:0] r;
        logic             fill;
        fill = s & v[6'(fw-1)];
        for (int b = 0; b < ACC_W; b++)
            r[b] = (b < fw) ? v[6'(b)] : fill;
        return r;
    endfunction

    assign w_start_lanes = lanes_f(cfga, cfgb);
    assign w_start_ok    = (state_q == IDLE) && start && (w_start_lanes != 3'd0);
    assign w_beat        = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_start_ok) state_d = (count == '0) ? DRAIN : ACCUM;
            ACCUM:   if (w_beat && rem_q == CNT_W'(1)) state_d = DRAIN;
            DRAIN:   if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == DRAIN);
        busy      = (state_q != IDLE);
    end

    always_comb begin
        lanes_d   = lanes_q;
        sgn_d     = sgn_q;
        rem_d     = rem_q;
        err_cfg_d = (state_q == IDLE) && start && (w_start_lanes == 3'd0);
        if (w_start_ok) begin
            lanes_d = w_start_lanes;
            sgn_d   = sgn;
            rem_d   = count;
        end else if (w_beat) begin
            rem_d = rem_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lanes_q   <= 3'd0;
            sgn_q     <= 1'b0;
            rem_q     <= '0;
            err_cfg_q <= 1'b0;
        end else begin
            lanes_q   <= lanes_d;
            sgn_q     <= sgn_d;
            rem_q     <= rem_d;
            err_cfg_q <= err_cfg_d;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) w_addend[i] = '0;
        case (lanes_q)
            3'd1: w_addend[0] = ext_f(in_data, 64, sgn_q);
            3'd2: for (int i = 0; i < 2; i++)
                      w_addend[i] = ext_f({32'b0, in_data[32*i +: 32]}, 32, sgn_q);
            3'd4: for (int i = 0; i < 4; i++)
                      w_addend[i] = ext_f({48'b0, in_data[16*i +: 16]}, 16, sgn_q);
            default: ;
        endcase
    end

    always_comb begin
        case (lanes_q)
            3'd1:    w_lane_en = 4'b0001;
            3'd2:    w_lane_en = 4'b0011;
            3'd4:    w_lane_en = 4'b1111;
            default: w_lane_en = 4'b0000;
        endcase
        w_lane_en = w_lane_en & {4{w_beat}};
    end

    generate
        for (genvar i = 0; i < 4; i++) begin : g_lane
            fusion_acc_lane #(.ACC_W(ACC_W)) u_lane (
                .clk    (clk),
                .reset  (reset),
                .clr    (w_start_ok),
                .en     (w_lane_en[i]),
                .sgn    (sgn_q),
                .addend (w_addend[i]),
                .acc    (w_lane_acc[i]),
                .sat    (w_lane_sat[i])
            );
            assign out_data[i*ACC_W +: ACC_W] = w_lane_acc[i];
        end
    endgenerate

    assign out_lanes = lanes_q;
    assign sat       = |w_lane_sat;
    assign err_cfg   = err_cfg_q;

endmodule

`default_nettype wire

// File: tb/tb_fusion_accumulator.sv
// ============================================================================
// tb_fusion_accumulator
// Randomised and directed checks of fusion_accumulator against a lane-sum model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fusion_accumulator;

    localparam int ACC_W = 32;
    localparam int CNT_W = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [1:0]         cfga, cfgb;
    logic               sgn;
    logic [CNT_W-1:0]   count;
    logic               in_valid;
    logic               in_ready;
    logic [63:0]        in_data;
    logic               out_valid;
    logic               out_ready;
    logic [4*ACC_W-1:0] out_data;
    logic [2:0]         out_lanes;
    logic               sat;
    logic               busy;
    logic               err_cfg;

    int checks = 0;
    int errors = 0;

    fusion_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cfga      (cfga),
        .cfgb      (cfgb),
        .sgn       (sgn),
        .count     (count),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_lanes (out_lanes),
        .sat       (sat),
        .busy      (busy),
        .err_cfg   (err_cfg)
    );

    always #5 clk = ~clk;

    function automatic int lanes_of(input logic [1:0] ca, input logic [1:0] cb);
        if (ca == 2'b10 && cb == 2'b10) return 1;
        if ((ca == 2'b10 && cb == 2'b01) || (ca == 2'b01 && cb == 2'b10)) return 2;
        return 4;
    endfunction

    // Lane sums as plain integers, clamped to the representable range after each add.
    function automatic void model(input int nl, input bit s, input logic [63:0] words[$],
                                  output logic [4*ACC_W-1:0] exp_d, output bit exp_s);
        longint      acc [4];
        longint      lo, hi, v;
        logic [31:0] f32;
        logic [15:0] f16;
        lo    = s ? -(longint'(1) <<< 31) : 0;
        hi    = s ? (longint'(1) <<< 31) - 1 : (longint'(1) <<< 32) - 1;
        exp_s = 0;
        for (int i = 0; i < 4; i++) acc[i] = 0;
        foreach (words[k]) begin
            for (int i = 0; i < nl; i++) begin
                if (nl == 4) begin
                    f16 = words[k][16*i +: 16];
                    v   = s ? longint'($signed(f16)) : longint'(f16);
                end else begin
                    f32 = words[k][32*i +: 32];
                    v   = s ? longint'($signed(f32)) : longint'(f32);
                end
                acc[i] = acc[i] + v;
                if (acc[i] > hi) begin acc[i] = hi; exp_s = 1; end
                if (acc[i] < lo) begin acc[i] = lo; exp_s = 1; end
            end
        end
        exp_d = '0;
        for (int i = 0; i < 4; i++) exp_d[i*ACC_W +: ACC_W] = acc[i][ACC_W-1:0];
    endfunction

    task automatic run_job(input string name, input logic [1:0] ca, input logic [1:0] cb,
                           input bit s, input logic [63:0] words[$], input int gap_max,
                           input int hold, input bit poke, input bit chk_lanes,
                           output logic [4*ACC_W-1:0] got);
        logic [4*ACC_W-1:0] exp_d;
        bit                 exp_s;
        int                 nl;
        int                 n;
        nl = lanes_of(ca, cb);
        model(nl, s, words, exp_d, exp_s);
        n = 0;
        while (busy !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s.idle busy got %b exp 0", name, busy); end
        start = 1'b1; cfga = ca; cfgb = cb; sgn = s; count = CNT_W'(words.size());
        @(negedge clk);
        start = 1'b0; cfga = 2'($urandom); cfgb = 2'($urandom); sgn = 1'($urandom);
        foreach (words[k]) begin
            repeat ($urandom_range(0, gap_max)) begin
                in_valid = 1'b0; in_data = {$urandom, $urandom};
                @(negedge clk);
            end
            in_valid = 1'b1; in_data = words[k];
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL %s.in_ready beat %0d got %b exp 1", name, k, in_ready); end
            @(negedge clk);
        end
        in_valid = 1'b0; in_data = {$urandom, $urandom};
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL %s.out_valid got %b exp 1", name, out_valid); end
        checks++;
        if (out_data !== exp_d) begin errors++; $display("FAIL %s.out_data got %h exp %h", name, out_data, exp_d); end
        checks++;
        if (sat !== exp_s) begin errors++; $display("FAIL %s.sat got %b exp %b", name, sat, exp_s); end
        if (chk_lanes) begin
            checks++;
            if (out_lanes !== 3'(nl)) begin errors++; $display("FAIL %s.out_lanes got %0d exp %0d", name, out_lanes, nl); end
        end
        got = out_data;
        for (int h = 0; h < hold; h++) begin
            start = poke && (h == 1); cfga = poke ? 2'b11 : 2'b10; cfgb = 2'b10;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d || in_ready !== 1'b0 || err_cfg !== 1'b0) begin
                errors++;
                $display("FAIL %s.hold%0d got v=%b rdy=%b err=%b d=%h exp v=1 rdy=0 err=0 d=%h",
                         name, h, out_valid, in_ready, err_cfg, out_data, exp_d);
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || err_cfg !== 1'b0) begin
            errors++; $display("FAIL %s.release got v=%b busy=%b err=%b exp 0 0 0", name, out_valid, busy, err_cfg);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; cfga = 2'b00; cfgb = 2'b00; sgn = 1'b0; count = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready, busy, err_cfg, sat} !== 5'b0 || out_data !== '0 || out_lanes !== 3'd0) begin
            errors++;
            $display("FAIL reset got v=%b rdy=%b busy=%b err=%b sat=%b lanes=%0d d=%h exp all 0",
                     out_valid, in_ready, busy, err_cfg, sat, out_lanes, out_data);
        end
    endtask

    task automatic test_directed();
        logic [63:0]        q[$];
        logic [4*ACC_W-1:0] got;
        q = '{64'hFFFF_FFFF_FFFF_FFFB, 64'd7, 64'd100};
        run_job("s8x8", 2'b10, 2'b10, 1'b1, q, 1, 0, 1'b0, 1'b1, got);
        checks++;
        if (got !== 128'd102) begin errors++; $display("FAIL s8x8.lane0 got %h exp 102", got); end
        q = '{{32'd20, 32'd10}, {32'd20, 32'd10}};
        run_job("u8x4", 2'b10, 2'b01, 1'b0, q, 0, 0, 1'b0, 1'b1, got);
        checks++;
        if (got !== {64'd0, 32'd40, 32'd20}) begin errors++; $display("FAIL u8x4.lanes got %h exp lane1=40 lane0=20", got); end
        q = '{64'hFFFF_0003_8000_0001};
        run_job("s2x2", 2'b00, 2'b00, 1'b1, q, 0, 0, 1'b0, 1'b1, got);
        checks++;
        if (got !== {32'hFFFF_FFFF, 32'd3, 32'hFFFF_8000, 32'd1}) begin
            errors++; $display("FAIL s2x2.lanes got %h exp {-1,3,-32768,1}", got);
        end
    endtask

    task automatic test_saturation();
        logic [63:0]        q[$];
        logic [4*ACC_W-1:0] got;
        q = '{64'h0000_0000_7000_0000, 64'h0000_0000_7000_0000};
        run_job("sat_pos", 2'b10, 2'b10, 1'b1, q, 0, 0, 1'b0, 1'b1, got);
        checks++;
        if (got[31:0] !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sat_pos.lane0 got %h exp 7fffffff", got[31:0]); end
        q = '{64'hFFFF_FFFF_9000_0000, 64'hFFFF_FFFF_9000_0000, 64'd5};
        run_job("sat_neg", 2'b10, 2'b10, 1'b1, q, 0, 0, 1'b0, 1'b1, got);
        q = '{64'h0000_0000_F000_0000, 64'h0000_0000_F000_0000};
        run_job("sat_uns", 2'b10, 2'b10, 1'b0, q, 0, 0, 1'b0, 1'b1, got);
    endtask

    task automatic test_random();
        logic [1:0]         codes[6];
        logic [63:0]        q[$];
        logic [4*ACC_W-1:0] got;
        int                 a, b;
        codes = '{2'b10, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00};
        for (int j = 0; j < 24; j++) begin
            a = $urandom_range(0, 5); b = $urandom_range(0, 5);
            q.delete();
            repeat ($urandom_range(1, 7)) begin
                if ($urandom_range(0, 1) == 0) q.push_back({$urandom, $urandom});
                else q.push_back({$urandom & 32'h00FF_00FF, $urandom & 32'h00FF_00FF});
            end
            run_job("random", codes[a], codes[b], 1'($urandom), q, 2, $urandom_range(0, 2), 1'b0, 1'b1, got);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0]        q[$];
        logic [4*ACC_W-1:0] got;
        q = '{{$urandom, $urandom}, {$urandom, $urandom}};
        run_job("bp", 2'b01, 2'b00, 1'b1, q, 0, 5, 1'b1, 1'b1, got);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || err_cfg !== 1'b0) begin
            errors++; $display("FAIL bp.ignored_start got busy=%b err=%b exp 0 0", busy, err_cfg);
        end
    endtask

    task automatic test_err_cfg();
        start = 1'b1; cfga = 2'b11; cfgb = 2'b10; sgn = 1'b0; count = 16'd3;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (err_cfg !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL err_cfg.pulse got err=%b busy=%b exp 1 0", err_cfg, busy);
        end
        @(negedge clk);
        checks++;
        if (err_cfg !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL err_cfg.clear got err=%b busy=%b exp 0 0", err_cfg, busy);
        end
    endtask

    task automatic test_count_zero();
        logic [63:0]        q[$];
        logic [4*ACC_W-1:0] got;
        q = '{64'h0001_0002_0003_0004};
        run_job("pre_zero", 2'b00, 2'b01, 1'b0, q, 0, 0, 1'b0, 1'b1, got);
        q.delete();
        run_job("count0", 2'b00, 2'b01, 1'b0, q, 0, 1, 1'b0, 1'b0, got);
    endtask

    task automatic test_reset_mid();
        logic [63:0]        q[$];
        logic [4*ACC_W-1:0] got;
        start = 1'b1; cfga = 2'b10; cfgb = 2'b10; sgn = 1'b1; count = 16'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (2) begin
            in_valid = 1'b1; in_data = 64'd1000;
            @(negedge clk);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({out_valid, in_ready, busy, sat} !== 4'b0 || out_data !== '0 || out_lanes !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid got v=%b rdy=%b busy=%b sat=%b lanes=%0d d=%h exp all 0",
                     out_valid, in_ready, busy, sat, out_lanes, out_data);
        end
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        q = '{64'd11, 64'd22, 64'd33};
        run_job("after_reset", 2'b10, 2'b10, 1'b1, q, 1, 0, 1'b0, 1'b1, got);
    endtask

    task automatic test_back_to_back();
        logic [63:0]        q[$];
        logic [4*ACC_W-1:0] got;
        for (int j = 0; j < 4; j++) begin
            q = '{{$urandom, $urandom}};
            run_job("b2b", 2'b01, 2'b01, 1'($urandom), q, 0, 0, 1'b0, 1'b1, got);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_saturation();
        test_err_cfg();
        test_count_zero();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
